// File: rtl/dsp_pkg.sv
// dsp_pkg -- shared constants and width helpers for the ADC front-end DSP.
//   SAMPLE_W  : ADC / FIR sample width
//   CIC_ORDER : number of integrator/comb sections in the decimator
//   clog2()   : ceiling log2, usable in constant expressions
//   cic_w()   : internal CIC register width for a given decimation ratio
package dsp_pkg;

   localparam int SAMPLE_W  = 12;
   localparam int CIC_ORDER = 2;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

   // Growth of an N-th order CIC is N*log2(R) bits on top of the input width.
   function automatic int cic_w(input int r);
      return SAMPLE_W + CIC_ORDER * clog2(r);
   endfunction

endpackage

// File: rtl/cic_comb.sv
// cic_comb -- one CIC differentiator section with its registered delay.
// On each en: y <= x - d, d <= x. vld follows en by one clock.
// Arithmetic is modulo 2^W; wrap-around is relied on by the CIC.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   en         input sample strobe
//   x [W]      input (integrator output or previous comb)
//   vld        output strobe, en delayed one clock
//   y [W]      registered difference
module cic_comb
   import dsp_pkg::*;
#(
   parameter int W = cic_w(16)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [W-1:0] x,
   output logic         vld,
   output logic [W-1:0] y
);

   logic [W-1:0] d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d   <= '0;
         y   <= '0;
         vld <= 1'b0;
      end else begin
         vld <= en;
         if (en) begin
            d <= x;
            y <= x - d;
         end
      end
   end

endmodule

// File: rtl/adc_cic_decim.sv
// adc_cic_decim -- 2nd-order CIC decimator in front of the FIR filters.
// Integrates 12-bit ADC samples on adc_vld, decimates by DEC_R, rounds
// back to 12 bits and presents the result on dout with an f_s pulse held
// high for FS_HI clocks. A result arriving while f_s is still high is
// dropped and sets the sticky ovr flag.
// Pipeline from the last sample of a block: integrator -> comb1 -> comb2
// -> round/output, so f_s rises 3 clocks after that adc_vld edge.
// Build option: define ADC_CIC_DECIM_OFFBIN_EN when adc_din is
// offset-binary; otherwise adc_din is two's complement.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   adc_vld        one-cycle sample strobe
//   adc_din [12]   ADC sample
//   dout [12]      signed decimated sample (FIR din)
//   f_s            sample-rate pulse (FIR f_s)
//   ovr            sticky overrun flag
module adc_cic_decim
   import dsp_pkg::*;
#(
   parameter int DEC_R = 16,
   parameter int FS_HI = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                adc_vld,
   input  logic [SAMPLE_W-1:0] adc_din,
   output logic [SAMPLE_W-1:0] dout,
   output logic                f_s,
   output logic                ovr
);

   localparam int LR = clog2(DEC_R);
   localparam int S  = CIC_ORDER * LR;
   localparam int W  = cic_w(DEC_R);
   localparam logic [LR-1:0] PH_LAST = LR'(DEC_R - 1);

   // ---------------- input format ----------------
   logic [SAMPLE_W-1:0] samp;
`ifdef ADC_CIC_DECIM_OFFBIN_EN
   // Offset-binary to two's complement: flip the MSB.
   assign samp = {~adc_din[SAMPLE_W-1], adc_din[SAMPLE_W-2:0]};
`else
   assign samp = adc_din;
`endif

   // ---------------- integrators + phase ----------------
   logic [W-1:0]  x_ext, i1, i2, i1_nxt;
   logic [LR-1:0] phase;
   logic          dec_stb;

   assign x_ext  = {{S{samp[SAMPLE_W-1]}}, samp};
   assign i1_nxt = i1 + x_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i1      <= '0;
         i2      <= '0;
         phase   <= '0;
         dec_stb <= 1'b0;
      end else begin
         dec_stb <= adc_vld && (phase == PH_LAST);
         if (adc_vld) begin
            i1    <= i1_nxt;
            i2    <= i2 + i1_nxt;
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
         end
      end
   end

   // ---------------- comb sections ----------------
   // dec_stb is registered with the final integrator update, so comb1
   // samples the block-end i2 on the next edge regardless of further
   // adc_vld traffic.
   logic         c1_vld, c2_vld;
   logic [W-1:0] c1, c2;

   cic_comb #(.W(W)) u_comb1 (
      .clk (clk),
      .rst (rst),
      .en  (dec_stb),
      .x   (i2),
      .vld (c1_vld),
      .y   (c1)
   );

   cic_comb #(.W(W)) u_comb2 (
      .clk (clk),
      .rst (rst),
      .en  (c1_vld),
      .x   (c1),
      .vld (c2_vld),
      .y   (c2)
   );

   // ---------------- round half up ----------------
   // (c2 + 2^(S-1)) >>> S == floor(c2 / 2^S) + c2[S-1]. Gain is exactly
   // DEC_R^2, so the top bits are pure sign and the add cannot overflow.
   logic [SAMPLE_W-1:0] y;
   logic                unused_lsbs;

   assign y = c2[W-1:S] + {{(SAMPLE_W-1){1'b0}}, c2[S-1]};
   // Bits below the rounding point do not influence y.
   assign unused_lsbs = ^c2[S-2:0];

   // ---------------- output / f_s generator ----------------
   logic [3:0] fs_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout   <= '0;
         f_s    <= 1'b0;
         ovr    <= 1'b0;
         fs_cnt <= '0;
      end else if (c2_vld && (fs_cnt == '0)) begin
         dout   <= y;
         f_s    <= 1'b1;
         fs_cnt <= 4'(FS_HI);
      end else begin
         // Result while the previous pulse is still running is dropped.
         if (c2_vld) ovr <= 1'b1;
         if (fs_cnt != '0) fs_cnt <= fs_cnt - 1'b1;
         f_s <= (fs_cnt > 4'd1);
      end
   end

endmodule

// File: doc/adc_cic_decim.md
# adc_cic_decim

Front-end decimator that feeds the 31-tap symmetric FIR filters (HPF/LPF).
- Accepts 12-bit ADC samples at a high rate, qualified by a strobe.
- Decimates them with a 2nd-order CIC filter by a power-of-two ratio, producing a 12-bit signed `dout` for the FIR `din` input.
- Generates the `f_s` sample-rate pulse, which the FIR edge-detects through its two-flop synchroniser.

## Interface
- `DEC_R`, default 16: decimation ratio. Power of two, 2..256.
- `FS_HI`, default 4: number of clk cycles `f_s` is held high per output sample. Range 2..15.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `adc_vld`  in  1  one-cycle strobe; `adc_din` is valid when high.
- `adc_din`  in  12  ADC sample. Signed two's complement by default; see Configuration.
- `dout`  out  12  signed decimated sample, connects to FIR `din`.
- `f_s`  out  1  sample-rate pulse, connects to FIR `f_s`.
- `ovr`  out  1  sticky overrun flag.

## Operation
- Widths:
  - S = 2·log2(DEC_R).
  - Internal width W = 12 + S, max 28 bits.
  - All integrator and comb arithmetic is modulo 2^W. Wrap-around is intentional and must not saturate.
- Integrators: on each `adc_vld`, `i1 <= i1 + sext(adc_din)` and `i2 <= i2 + i1_new`, where `i1_new` is the updated value of `i1`.
- Phase counter:
  - Range 0..DEC_R-1, advances only on `adc_vld`, wraps to 0.
  - When `adc_vld` arrives with count = DEC_R-1, a decimation strobe is registered.
- Comb stage (on the decimation strobe):
  - `c1 = i2 - d1`, `d1 <= i2`.
  - `c2 = c1 - d2`, `d2 <= c1`.
- Scaling:
  - `y = (c2 + 2^(S-1)) >>> S`, arithmetic shift with round-half-up.
  - CIC gain is exactly DEC_R², so `y` always lies in -2048..2047. No saturation logic is needed.
- Output handshake, when `y` is ready:
  - If the `f_s` counter is idle: `dout <= y`, `f_s <= 1`, load the counter with FS_HI.
  - If `f_s` is still high: the sample is dropped, `dout` is unchanged, and `ovr <= 1`. `ovr` stays set until reset.
- `f_s` counter: decrements each clk; `f_s` returns to 0 when it reaches 0. The low time between pulses is therefore at least 1 clk.
- Settling: the first two decimated outputs after reset carry CIC transient. They are still emitted with `f_s`.

## Timing
- Reset values: `dout` = 0, `f_s` = 0, `ovr` = 0. Integrators, combs, delays and counters are all 0.
- Latency: `adc_vld` sampled at edge E0 with the last sample of a block gives `dout` updated and `f_s` rising at edge E0+3. Pipeline: integrator, then comb, then round/output.
- `dout` is stable from the `f_s` rising edge until the next accepted sample. The FIR samples `din` 2 clk after `f_s` rises, which falls within that window.
- Legal input rate: DEC_R × (`adc_vld` spacing) ≥ FS_HI + 1 cycles. Otherwise `ovr` asserts.
- `adc_vld` on consecutive cycles is legal; there are no back-to-back restrictions.
- Reset asserted mid-block: everything clears asynchronously. The next block starts at phase 0 on the first `adc_vld` after release.

## Configuration
- Macro: `ADC_CIC_DECIM_OFFBIN_EN`.
- Defined: `adc_din` is offset-binary (0 = most negative). It is converted to two's complement by inverting bit 11 before the integrators.
- Undefined: `adc_din` is used as two's complement directly.
- All other behaviour is identical in both builds.

## Structure
- Package `dsp_pkg`:
  - `SAMPLE_W` = 12.
  - `CIC_ORDER` = 2.
  - `clog2` function.
  - Width helper `cic_w(R) = SAMPLE_W + CIC_ORDER·clog2(R)`.
- Sub-module `cic_comb`: one differentiator section with its registered delay, parameterised by W. It is instantiated twice.
- The integrators, phase counter, rounding and `f_s` generator stay in the top module.

## Test plan
- Reset: hold `rst` = 0 with random `adc_din` → `dout` = 0, `f_s` = 0, `ovr` = 0. After release, the first `f_s` comes 3 clk after the 16th `adc_vld`.
- DC settling: DEC_R = 16, `adc_din` = +1000 every 4th clk → from the 3rd output onward `dout` = 1000, with `f_s` high exactly 4 clk each 64 clk.
- Full scale and wrap-around: constant −2048, then constant +2047, for 2000 outputs → settled `dout` = −2048 / +2047 exactly, `ovr` = 0. Confirms no integrator-wrap errors.
- Impulse: a single +2047 sample, zeros elsewhere, DEC_R = 16 → decimated response matches a golden model of the 2nd-order CIC with rounding; the sum of outputs equals `round(2047/16)` within ±1 LSB.
- Overrun: DEC_R = 2, FS_HI = 4, `adc_vld` every clk → `ovr` rises on the second decimated sample; `dout` holds the first value until `f_s` falls.
- Mid-operation reset: assert `rst` at phase 7 → all outputs are 0 asynchronously. After release, a DC of 500 settles to `dout` = 500 on the 3rd output, and `ovr` stays 0.
